// File: rtl/key_click_decoder.sv
// key_click_decoder
//   Classifies bursts of key presses into single, double or triple clicks.
//   Each press restarts a WIN_CNT-cycle window. The window expiring after
//   one or two presses reports single/double. A third press inside the
//   window reports triple at once.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   key_pulse     one-cycle press pulse from the debouncer
//   single_click  one-cycle pulse, window closed after one press
//   double_click  one-cycle pulse, window closed after two presses
//   triple_click  one-cycle pulse, third press inside the window
//   busy          high while a click sequence is open
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no sequence open, waiting for the first press
// ONE   | one press seen, window running
// TWO   | two presses seen, window running
module key_click_decoder #(
  parameter logic [23:0] WIN_CNT = 24'd15_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_pulse,
  output logic single_click,
  output logic double_click,
  output logic triple_click,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } state_t;

  localparam logic [23:0] CNT_LAST = WIN_CNT - 24'd1;

  state_t      state;
  logic [23:0] cnt;

  // busy is assigned alongside every state change so that it always equals
  // (state != IDLE) without a combinational decode on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 24'd0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      triple_click <= 1'b0;
      busy         <= 1'b0;
    end else begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      triple_click <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 24'd0;
          if (key_pulse) begin
            state <= ONE;
            busy  <= 1'b1;
          end
        end
        ONE: begin
          // A press on the last window cycle wins over the timeout.
          if (key_pulse) begin
            state <= TWO;
            cnt   <= 24'd0;
          end else if (cnt == CNT_LAST) begin
            state        <= IDLE;
            cnt          <= 24'd0;
            single_click <= 1'b1;
            busy         <= 1'b0;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        TWO: begin
          if (key_pulse) begin
            state        <= IDLE;
            cnt          <= 24'd0;
            triple_click <= 1'b1;
            busy         <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state        <= IDLE;
            cnt          <= 24'd0;
            double_click <= 1'b1;
            busy         <= 1'b0;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 24'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_click_decoder.sv
module tb_key_click_decoder;

  localparam int KIND_SINGLE = 1;
  localparam int KIND_DOUBLE = 2;
  localparam int KIND_TRIPLE = 3;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic clk;
  logic rst;
  logic key_pulse;
  logic single_click;
  logic double_click;
  logic triple_click;
  logic busy;

  int   errors;
  int   checks;
  int   cyc;
  exp_t click_q[$];
  exp_t busy_q[$];
  int   press_q[$];
  int   rst_q[$];

  key_click_decoder #(.WIN_CNT(24'd10)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_pulse    (key_pulse),
    .single_click (single_click),
    .double_click (double_click),
    .triple_click (triple_click),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int click_kind();
    if (single_click) return KIND_SINGLE;
    if (double_click) return KIND_DOUBLE;
    if (triple_click) return KIND_TRIPLE;
    return 0;
  endfunction

  // Compares the outputs of the current cycle against the scoreboards.
  task automatic monitor();
    int   kind;
    exp_t e;
    checks++;
    assert ($onehot0({single_click, double_click, triple_click})) else begin
      errors++;
      $error("FAIL onehot cyc=%0d observed s/d/t=%b%b%b expected at most one high",
             cyc, single_click, double_click, triple_click);
    end
    kind = click_kind();
    if (kind != 0) begin
      checks++;
      if (click_q.size() == 0) begin
        errors++;
        $error("FAIL click cyc=%0d observed kind=%0d expected none", cyc, kind);
      end else begin
        e = click_q.pop_front();
        assert (e.cyc == cyc && e.val == kind) else begin
          errors++;
          $error("FAIL click observed kind=%0d at cyc=%0d expected kind=%0d at cyc=%0d",
                 kind, cyc, e.val, e.cyc);
        end
      end
    end else if (click_q.size() != 0 && click_q[0].cyc <= cyc) begin
      checks++;
      e = click_q.pop_front();
      errors++;
      $error("FAIL click_missing cyc=%0d observed none expected kind=%0d", cyc, e.val);
    end
    while (busy_q.size() != 0 && busy_q[0].cyc == cyc) begin
      e = busy_q.pop_front();
      checks++;
      assert (busy === e.val[0]) else begin
        errors++;
        $error("FAIL busy cyc=%0d observed %b expected %0d", cyc, busy, e.val);
      end
    end
  endtask

  // Drives the inputs of the current cycle and moves to the next one.
  task automatic run_cycle(input logic kp, input logic r);
    key_pulse = kp;
    rst       = r;
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic do_reset();
    click_q.delete();
    busy_q.delete();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);
    cyc = 0;
  endtask

  task automatic push_click(input int c, input int kind);
    exp_t e;
    e.cyc = c;
    e.val = kind;
    click_q.push_back(e);
  endtask

  task automatic push_busy(input int c, input int v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    busy_q.push_back(e);
  endtask

  task automatic run_scenario(input string name, input int n);
    logic kp;
    logic r;
    for (int c = 0; c < n; c++) begin
      kp = 1'b0;
      r  = 1'b0;
      foreach (press_q[i]) if (press_q[i] == cyc) kp = 1'b1;
      foreach (rst_q[i])   if (rst_q[i] == cyc)   r  = 1'b1;
      run_cycle(kp, r);
    end
    checks++;
    assert (click_q.size() == 0 && busy_q.size() == 0) else begin
      errors++;
      $error("FAIL %s_leftover observed pending=%0d expected 0", name,
             click_q.size() + busy_q.size());
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    rst       = 1'b1;
    key_pulse = 1'b1;

    // Reset with key_pulse high must leave everything idle.
    do_reset();
    checks++;
    assert ({single_click, double_click, triple_click, busy} === 4'b0000) else begin
      errors++;
      $error("FAIL reset observed s/d/t/b=%b%b%b%b expected 0000",
             single_click, double_click, triple_click, busy);
    end

    // Lone press: single after the full window.
    do_reset();
    press_q = '{5};
    rst_q   = {};
    push_busy(5, 0);
    for (int c = 6; c <= 15; c++) push_busy(c, 1);
    push_busy(16, 0);
    push_click(16, KIND_SINGLE);
    run_scenario("single", 25);

    // Two presses: window restarts on the second.
    do_reset();
    press_q = '{5, 12};
    push_busy(22, 1);
    push_busy(23, 0);
    push_click(23, KIND_DOUBLE);
    run_scenario("double", 30);

    // Three presses: triple on the cycle after the third.
    do_reset();
    press_q = '{5, 12, 20};
    push_busy(20, 1);
    push_busy(21, 0);
    push_busy(22, 0);
    push_click(21, KIND_TRIPLE);
    run_scenario("triple", 35);

    // Second press exactly on the last window cycle wins over timeout.
    do_reset();
    press_q = '{5, 15};
    push_busy(16, 1);
    push_click(26, KIND_DOUBLE);
    run_scenario("boundary", 35);

    // Reset mid-sequence discards it; later press starts fresh.
    do_reset();
    press_q = '{5, 30};
    rst_q   = '{8};
    push_busy(8, 1);
    push_busy(9, 0);
    push_busy(30, 0);
    push_busy(31, 1);
    push_click(41, KIND_SINGLE);
    run_scenario("mid_reset", 50);
    rst_q = {};

    // Held key counts one press per cycle; press on triple cycle restarts.
    do_reset();
    press_q = '{5, 6, 7, 8};
    push_busy(8, 0);
    push_busy(9, 1);
    push_click(8, KIND_TRIPLE);
    push_click(19, KIND_SINGLE);
    run_scenario("held", 28);

    // Press in the same cycle as a single_click opens a new sequence.
    do_reset();
    press_q = '{3, 14};
    push_busy(14, 0);
    push_busy(15, 1);
    push_click(14, KIND_SINGLE);
    push_click(25, KIND_SINGLE);
    run_scenario("back_to_back", 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_click_decoder.md
KEY_CLICK_DECODER -- requirements
Module: key_click_decoder

Interface
REQ-001 SHALL have parameter WIN_CNT, default 24'd15_000_000, the click window in clk cycles (300 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port key_pulse  input  1  one-cycle press pulse from the key debouncer; synchronous to clk.
REQ-005 SHALL have port single_click  output  1  one-cycle pulse: window closed after exactly one press.
REQ-006 SHALL have port double_click  output  1  one-cycle pulse: window closed after exactly two presses.
REQ-007 SHALL have port triple_click  output  1  one-cycle pulse: third press inside the window.
REQ-008 SHALL have port busy  output  1  high while a click sequence is open (state not IDLE).

Function
REQ-009 SHALL implement FSM states IDLE, ONE, TWO, with a 24-bit window counter cnt.
REQ-010 In IDLE, key_pulse=1 SHALL move to ONE with cnt cleared to 0; otherwise it SHALL hold IDLE with cnt held at 0.
REQ-011 In ONE or TWO with key_pulse=0 and cnt != WIN_CNT-1, cnt SHALL increment by 1.
REQ-012 In ONE, key_pulse=1 SHALL move to TWO and clear cnt to 0 (window restarts on every press).
REQ-013 In TWO, key_pulse=1 SHALL move to IDLE, clear cnt, and assert triple_click on the next cycle.
REQ-014 In ONE with cnt == WIN_CNT-1 and key_pulse=0, the FSM SHALL move to IDLE, clear cnt, and assert single_click on the next cycle.
REQ-015 In TWO with cnt == WIN_CNT-1 and key_pulse=0, the FSM SHALL move to IDLE, clear cnt, and assert double_click on the next cycle.
REQ-016 When key_pulse=1 coincides with cnt == WIN_CNT-1, the press SHALL win: it is counted as a click per REQ-012/REQ-013 and no timeout output is produced.
REQ-017 All three click outputs SHALL be registered and mutually exclusive, each high for exactly one cycle per event.
REQ-018 Latency: a lone press at cycle t SHALL give single_click high in cycle t+WIN_CNT+1; a third press at cycle t SHALL give triple_click high in cycle t+1.
REQ-019 busy SHALL be registered and equal to (state != IDLE), so it is high from the cycle after the first press until the cycle the click output is asserted.
REQ-020 key_pulse held high for consecutive cycles SHALL count as one press per cycle. There is no edge detection; the input contract is single-cycle pulses.
REQ-021 A press arriving in the same cycle that a click output is high SHALL start a new sequence: IDLE moves to ONE.
REQ-022 cnt SHALL never exceed WIN_CNT-1 and SHALL never wrap.

Reset
REQ-023 While rst=1 at a clk edge, the block SHALL set state=IDLE, cnt=0, single_click=0, double_click=0, triple_click=0 and busy=0, ignoring key_pulse.
REQ-024 Reset asserted mid-sequence SHALL discard the open sequence with no click output; the first press after rst deasserts SHALL start a fresh ONE.
REQ-025 No output SHALL depend on any state that rst does not initialize.

Verification (benches use WIN_CNT=10)
REQ-026 Single press at cycle 5, then idle -> single_click high in cycle 16 only; busy high in cycles 6..15, low in cycle 16.
REQ-027 Presses at cycles 5 and 12 -> double_click high in cycle 23 only; no single_click.
REQ-028 Presses at cycles 5, 12 and 20 -> triple_click high in cycle 21; busy low from cycle 21; no single_click or double_click.
REQ-029 Press at cycle 5, second press at cycle 15 (cnt=9 boundary) -> no single_click; double_click high in cycle 26.
REQ-030 Press at cycle 5, rst=1 in cycle 8, released in cycle 9 -> no click outputs through cycle 40; a press at cycle 30 -> single_click high in cycle 41.
REQ-031 key_pulse held high for cycles 5..7 -> triple_click high in cycle 8; a fresh press at cycle 8 -> busy high in cycle 9.
